// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: prioritised per-stage write/flush
// controls, the mult/div busy sequencer and saturating stall/flush counters.
module pipeline_stall_controller #(
  parameter int unsigned MULDIV_LATENCY = 32,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_hazard,
  input  logic             ex_branch_taken,
  input  logic             ex_muldiv_start,
  input  logic             id_uses_hilo,
  input  logic             dmem_wait,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             muldiv_busy,
  output logic             muldiv_done,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] CNT_INIT = 8'(MULDIV_LATENCY - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       hilo_stall;

  // Reset is synchronous, so the busy flags are masked while it is asserted.
  assign muldiv_busy = (state == BUSY) && !reset;
  assign muldiv_done = muldiv_busy && (cnt == '0);
  assign hilo_stall  = muldiv_busy && id_uses_hilo && !muldiv_done;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if (!reset) begin
      if (dmem_wait) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use_hazard || hilo_stall) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_muldiv_start && !dmem_wait) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
      if (!pc_write && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if (if_id_flush && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// stimulus compared every cycle against a remaining-cycles behavioural model.
module tb_pipeline_stall_controller;

  localparam int LAT = 4;
  localparam int CW  = 6;
  localparam int SAT = 63;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_use_hazard = 1'b1, ex_branch_taken = 1'b1, ex_muldiv_start = 1'b1;
  logic id_uses_hilo = 1'b1, dmem_wait = 1'b1;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic ex_mem_write, mem_wb_write, muldiv_busy, muldiv_done;
  logic [CW-1:0] stall_count, flush_count;

  int passed = 0;
  int total  = 0;
  bit en     = 1'b0;

  pipeline_stall_controller #(.MULDIV_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .load_use_hazard(load_use_hazard), .ex_branch_taken(ex_branch_taken),
    .ex_muldiv_start(ex_muldiv_start), .id_uses_hilo(id_uses_hilo),
    .dmem_wait(dmem_wait),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: rem = busy cycles still to come, including the current one.
  int rem = 0, m_stall = 0, m_flush = 0;

  // {pcw, ifw, iff, idw, idf, exw, mww, busy, done}
  function automatic logic [8:0] expect_ctl();
    logic bsy, dn;
    if (reset) return 9'b110101100;
    bsy = rem > 0;
    dn  = rem == 1;
    if (dmem_wait)                                    return {7'b0000000, bsy, dn};
    if (ex_branch_taken)                              return {7'b1111111, bsy, dn};
    if (load_use_hazard || (bsy && id_uses_hilo && !dn)) return {7'b0001111, bsy, dn};
    return {7'b1101011, bsy, dn};
  endfunction

  always @(posedge clk) begin
    logic [8:0] e;
    e = expect_ctl();
    if (reset) begin
      rem <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      if (!e[8] && m_stall < SAT) m_stall <= m_stall + 1;
      if (e[6] && m_flush < SAT) m_flush <= m_flush + 1;
      if (rem > 0) rem <= rem - 1;
      else if (ex_muldiv_start && !dmem_wait) rem <= LAT;
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (en) begin
      e = expect_ctl();
      chk("pc_write",     int'(pc_write),     int'(e[8]));
      chk("if_id_write",  int'(if_id_write),  int'(e[7]));
      chk("if_id_flush",  int'(if_id_flush),  int'(e[6]));
      chk("id_ex_write",  int'(id_ex_write),  int'(e[5]));
      chk("id_ex_flush",  int'(id_ex_flush),  int'(e[4]));
      chk("ex_mem_write", int'(ex_mem_write), int'(e[3]));
      chk("mem_wb_write", int'(mem_wb_write), int'(e[2]));
      chk("muldiv_busy",  int'(muldiv_busy),  int'(e[1]));
      chk("muldiv_done",  int'(muldiv_done),  int'(e[0]));
      chk("stall_count",  int'(stall_count),  m_stall);
      chk("flush_count",  int'(flush_count),  m_flush);
    end
  end

  task automatic cyc(input logic rst, input logic lu, input logic br,
                     input logic st, input logic hilo, input logic dw);
    @(posedge clk); #1;
    reset = rst; load_use_hazard = lu; ex_branch_taken = br;
    ex_muldiv_start = st; id_uses_hilo = hilo; dmem_wait = dw;
  endtask

  initial begin
    int nb, nd;
    @(posedge clk); #1;
    en = 1'b1;
    // 1: reset held with all inputs high
    cyc(1,1,1,1,1,1); cyc(1,1,1,1,1,1);
    @(negedge clk);
    chk("rst_pc_write", int'(pc_write), 1);
    chk("rst_flush", int'(if_id_flush), 0);
    chk("rst_busy", int'(muldiv_busy), 0);
    chk("rst_stall_count", int'(stall_count), 0);
    cyc(0,0,0,0,0,0);
    // 2: single load-use cycle
    cyc(0,1,0,0,0,0);
    @(negedge clk);
    chk("lu_pc_write", int'(pc_write), 0);
    chk("lu_id_ex_flush", int'(id_ex_flush), 1);
    chk("lu_ex_mem_write", int'(ex_mem_write), 1);
    cyc(0,0,0,0,0,0);
    @(negedge clk);
    chk("lu_after_pc_write", int'(pc_write), 1);
    chk("lu_stall_count", int'(stall_count), 1);
    // 3: branch beats load-use
    cyc(1,0,0,0,0,0);
    cyc(0,1,1,0,0,0);
    @(negedge clk);
    chk("br_pc_write", int'(pc_write), 1);
    chk("br_if_id_flush", int'(if_id_flush), 1);
    cyc(0,0,0,0,0,0);
    @(negedge clk);
    chk("br_flush_count", int'(flush_count), 1);
    chk("br_stall_count", int'(stall_count), 0);
    // 4: mult/div with dependent ID instruction, extra start in cycle 2
    cyc(1,0,0,0,0,0);
    cyc(0,0,0,1,0,0);
    for (int c = 1; c <= 4; c++) begin
      cyc(0,0,0,(c == 2),1,0);
      @(negedge clk);
      chk($sformatf("md_busy_c%0d", c), int'(muldiv_busy), 1);
      chk($sformatf("md_done_c%0d", c), int'(muldiv_done), (c == 4) ? 1 : 0);
      chk($sformatf("md_pc_write_c%0d", c), int'(pc_write), (c == 4) ? 1 : 0);
    end
    cyc(0,0,0,0,0,0);
    @(negedge clk);
    chk("md_busy_after", int'(muldiv_busy), 0);
    chk("md_stall_count", int'(stall_count), 3);
    // 5: freeze defers branch and start
    cyc(1,0,0,0,0,0);
    cyc(0,0,1,1,0,1);
    @(negedge clk);
    chk("frz_pc_write", int'(pc_write), 0);
    chk("frz_mem_wb_write", int'(mem_wb_write), 0);
    chk("frz_flush", int'(if_id_flush), 0);
    cyc(0,0,1,1,0,1);
    @(negedge clk);
    chk("frz_busy", int'(muldiv_busy), 0);
    cyc(0,0,1,1,0,0);
    @(negedge clk);
    chk("frz_rel_flush", int'(if_id_flush), 1);
    cyc(0,0,0,0,0,0);
    @(negedge clk);
    chk("frz_rel_busy", int'(muldiv_busy), 1);
    chk("frz_stall_count", int'(stall_count), 2);
    // 6: reset mid-busy aborts without done, then a full-length run
    cyc(1,0,0,0,0,0);
    cyc(0,0,0,1,0,0);
    cyc(0,0,0,0,0,0); cyc(0,0,0,0,0,0);
    cyc(1,0,0,0,0,0);
    @(negedge clk);
    chk("abort_done", int'(muldiv_done), 0);
    cyc(0,0,0,0,0,0);
    @(negedge clk);
    chk("abort_busy", int'(muldiv_busy), 0);
    cyc(0,0,0,1,0,0);
    nb = 0; nd = 0;
    for (int c = 0; c < 7; c++) begin
      cyc(0,0,0,0,0,0);
      @(negedge clk);
      nb += int'(muldiv_busy);
      nd += int'(muldiv_done);
    end
    chk("restart_busy_cycles", nb, LAT);
    chk("restart_done_pulses", nd, 1);
    // Random traffic; counters saturate at 63 along the way.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 6) == 0), ($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
    end
    @(negedge clk);
    chk("sat_stall_count", int'(stall_count), m_stall);
    @(posedge clk); #1;
    en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Takes hazard requests and produces per-stage write-enable and flush controls with a fixed priority. Sources: the ID-stage load-use detector, EX-stage taken branch/jump, the multi-cycle mult/div unit, and the MEM-stage data-memory wait.
- Owns the mult/div busy sequencer and saturating stall/flush performance counters.
- Sits beside the hazard detection unit; its outputs drive PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
MULDIV_LATENCY, 32, cycles the mult/div unit is busy after a start; legal range 1..255.
CNT_W, 32, width of each performance counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load_use_hazard  input  1  ID instruction depends on a load in EX (from hazard detection)
ex_branch_taken  input  1  branch/jump in EX resolved taken; PC loads target this cycle
ex_muldiv_start  input  1  valid mult/div instruction in EX
id_uses_hilo  input  1  ID instruction reads HI/LO or is mult/div
dmem_wait  input  1  data memory not ready for MEM-stage access
pc_write  output  1  PC register enable
if_id_write  output  1  IF/ID enable
if_id_flush  output  1  IF/ID clear to NOP
id_ex_write  output  1  ID/EX enable
id_ex_flush  output  1  ID/EX clear to bubble
ex_mem_write  output  1  EX/MEM enable
mem_wb_write  output  1  MEM/WB enable
muldiv_busy  output  1  mult/div sequencer active
muldiv_done  output  1  one-cycle pulse, last busy cycle
stall_count  output  CNT_W  cycles with pc_write=0
flush_count  output  CNT_W  cycles with if_id_flush=1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset state: while reset=1 and on the following edge:
  - state=IDLE, down-counter=0, both perf counters=0.
  - Outputs: muldiv_busy=0, muldiv_done=0.
  - All *_write=1, all flushes=0.
  - All other inputs are ignored.
  - Reset mid-mult/div aborts it with no done pulse.
- Timing: stall/flush outputs are combinational from inputs and current state, so they take effect in the same cycle. State and counters update on the clock edge.
- Default (no request): all writes=1, flushes=0.
- Priority, evaluated each cycle with first match winning:
  1. dmem_wait=1: freeze. pc_write, if_id_write, id_ex_write, ex_mem_write and mem_wb_write are all 0; no flushes. Any branch, load-use or mult/div request is deferred and re-evaluated next cycle. MEM/WB is held, and WB re-writes the same value harmlessly.
  2. ex_branch_taken=1: pc_write=1, if_id_flush=1, id_ex_flush=1, other writes=1.
  3. load_use_hazard=1, or (muldiv_busy=1 and id_uses_hilo=1 and muldiv_done=0): pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1, mem_wb_write=1.
  4. Otherwise: default.
- Mult/div FSM, states IDLE and BUSY:
  - IDLE -> BUSY when ex_muldiv_start=1 and dmem_wait=0. The start is not accepted while frozen, so a frozen instruction cannot start twice. On entry, down-counter = MULDIV_LATENCY-1.
  - In BUSY: muldiv_busy=1. The counter decrements every cycle, including frozen cycles, because the unit runs independently.
  - When the counter is 0: muldiv_done=1 for that cycle and the state returns to IDLE. HI/LO is valid at the end of the done cycle, so the HI/LO stall is released in the done cycle.
  - With MULDIV_LATENCY=1: busy for exactly the one cycle after start, with done in that cycle.
  - ex_muldiv_start while BUSY is ignored. It cannot occur legally because priority 3 holds it in ID.
- Independent instructions (id_uses_hilo=0) flow freely while BUSY.
- Simultaneous events:
  - Branch together with load-use or HI/LO stall: the branch wins and the ID instruction is flushed.
  - ex_muldiv_start together with ex_branch_taken: the start is accepted and the flush is applied.
- Counters:
  - stall_count += 1 on every non-reset cycle with pc_write=0. This includes freeze cycles.
  - flush_count += 1 on every cycle with if_id_flush=1.
  - Both saturate at all-ones and never wrap.

Test Plan:
1. Reset held 3 cycles with all inputs =1 -> during and after reset: all writes=1, flushes=0, busy=0, counters=0.
2. load_use_hazard=1 for 1 cycle -> that cycle: pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1; next cycle: default; stall_count=1.
3. ex_branch_taken=1 together with load_use_hazard=1 -> pc_write=1, if_id_flush=1, id_ex_flush=1; flush_count=1, stall_count=0.
4. MULDIV_LATENCY=4; ex_muldiv_start at cycle 0; id_uses_hilo=1 in cycles 1..4:
   - busy in cycles 1..4, muldiv_done only in cycle 4.
   - pc_write=0 in cycles 1..3 and 1 in cycle 4.
   - stall_count=3.
   - A second start in cycle 2 is ignored.
5. dmem_wait=1 for 2 cycles together with ex_branch_taken=1 and ex_muldiv_start=1:
   - every write=0, no flush, busy stays 0.
   - On the cycle dmem_wait drops: flushes apply and busy=1 next cycle.
   - stall_count=2.
6. Reset asserted mid-BUSY (counter=10) -> next cycle busy=0, no done pulse; a new start gives the full MULDIV_LATENCY.
